// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared func3 codes, FSM states and decode helpers for lsu_align_ctrl
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
`ifdef LSU_MISALIGN_EN
        RD1  = 3'd2,
        WR1  = 3'd4,
`endif
        WR0  = 3'd3,
        DONE = 3'd5
    } lsu_state_t;

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_cross(input logic [1:0] off, input logic [2:0] size);
        return ({1'b0, off} + size) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_align_ctrl_lane.sv
// rtl/lsu_align_ctrl_lane.sv - lsu_lane_align: 64-bit line extract/extend and store byte merge
module lsu_lane_align (
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_lo,
    output logic [31:0] merged_hi
);

    logic [63:0] line;
    logic [63:0] wline;
    logic [63:0] merged;
    logic [31:0] shifted;
    logic [7:0]  base_mask;
    logic [7:0]  mask;
    logic [5:0]  sh;

    always_comb begin
        line    = {hi, lo};
        sh      = {1'b0, off, 3'b000};
        shifted = 32'(line >> sh);
        case (size)
            3'd1:    load_data = sext ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'b0, shifted[7:0]};
            3'd2:    load_data = sext ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Bytes outside the mask keep whatever was read back from memory.
    always_comb begin
        case (size)
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        mask   = base_mask << off;
        wline  = {32'b0, wdata} << sh;
        merged = '0;
        for (int k = 0; k < 8; k++) begin
            merged[8*k +: 8] = mask[k] ? wline[8*k +: 8] : line[8*k +: 8];
        end
        merged_lo = merged[31:0];
        merged_hi = merged[63:32];
    end

endmodule

// File: rtl/lsu_align_ctrl.sv
// rtl/lsu_align_ctrl.sv - load/store alignment FSM issuing aligned word accesses to data_mem
// Define LSU_MISALIGN_EN to split word-crossing accesses; otherwise they return resp_err.
module lsu_align_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic [2:0]        mem_func3,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi_q, hi_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] w0;
    logic [2:0]        size;
    logic [2:0]        req_size;
    logic              req_err;
    logic              req_aligned_sw;
    logic [31:0]       load_data;
    logic [31:0]       merged_lo;
    logic [31:0]       merged_hi;

    assign w0       = {addr_q[ADDR_W-1:2], 2'b00};
    assign size     = f3_size(func3_q);
    assign req_size = f3_size(req_func3);
    assign req_aligned_sw = req_we && (req_addr[1:0] == 2'b00) && (req_size == 3'd4);

`ifdef LSU_MISALIGN_EN
    logic [ADDR_W-1:0] w1;
    logic              cross;
    assign w1      = w0 + ADDR_W'(4);
    assign cross   = is_cross(addr_q[1:0], size);
    assign req_err = !f3_legal(req_we, req_func3);
`else
    logic req_cross;
    assign req_cross = is_cross(req_addr[1:0], req_size);
    assign req_err   = !f3_legal(req_we, req_func3) || req_cross;
`endif

    lsu_lane_align u_lane (
        .lo        (lo_q),
        .hi        (hi_q),
        .off       (addr_q[1:0]),
        .size      (size),
        .sext      (!func3_q[2]),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged_lo (merged_lo),
        .merged_hi (merged_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            func3_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    lo_d    = '0;
                    hi_d    = '0;
                    err_d   = req_err;
                    if (req_err)             state_d = DONE;
                    else if (req_aligned_sw) state_d = WR0;
                    else                     state_d = RD0;
                end
            end
            RD0: begin
                lo_d    = mem_rdata;
                state_d = we_q ? WR0 : DONE;
`ifdef LSU_MISALIGN_EN
                if (cross) state_d = RD1;
`endif
            end
`ifdef LSU_MISALIGN_EN
            RD1: begin
                hi_d    = mem_rdata;
                state_d = we_q ? WR0 : DONE;
            end
            WR1: state_d = DONE;
`endif
            WR0: begin
                state_d = DONE;
`ifdef LSU_MISALIGN_EN
                if (cross) state_d = WR1;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs depend only on state and latched registers.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_func3  = F3_W;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD0:  mem_addr  = w0;
`ifdef LSU_MISALIGN_EN
            RD1:  mem_addr  = w1;
            WR1: begin
                mem_addr  = w1;
                mem_wdata = merged_hi;
                mem_we    = 1'b1;
            end
`endif
            WR0: begin
                mem_addr  = w0;
                mem_wdata = merged_lo;
                mem_we    = 1'b1;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'b0 : load_data;
            end
            default: ;
        endcase
    end

endmodule
